pkt_ser: RTL and testbench
==========================

# pkt_ser

Packet serializer that drains the 10-bit packet FIFO from its read side and transmits each packet on a single-wire, UART-style serial line. It sits at the FIFO's output: it watches `empty`, samples the show-ahead head word on `pkti`, pops it with a one-cycle `re` pulse, and shifts the frame out LSB first at a programmable bit period.

## Interface
- `BAUD_DIV`, default 4: clock cycles per serial bit; legal range 1..65535.
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pkti`  in  10: FIFO head word (show-ahead: valid combinationally whenever `empty`=0).
- `empty`  in  1: FIFO empty flag.
- `re`  out  1: FIFO pop strobe; exactly one cycle per packet taken.
- `tx_en`  in  1: when 0, no new frame starts; a frame in flight always completes.
- `txd`  out  1: serial line, idles high, registered.
- `busy`  out  1: high from the cycle after a pop through the last stop-bit cycle.
- `frame_done`  out  1: one-cycle pulse in the last stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, PAR (only with macro), STOP.
- Pop condition: (state==IDLE, or last cycle of STOP) and `tx_en`=1 and `empty`=0. In that cycle `re`=1 (decoded from registered state plus inputs) and `pkti` is captured into a 10-bit shift register; next state START.
- START: `txd`=0 for BAUD_DIV cycles -> DATA.
- DATA: 10 bits, `pkti[0]` first, each held BAUD_DIV cycles; 4-bit bit counter 0..9 -> PAR (macro) or STOP.
- STOP: `txd`=1 for BAUD_DIV cycles; `frame_done`=1 in its last cycle; then START if the pop condition holds, else IDLE.
- Baud counter counts 0..BAUD_DIV-1, sized ceil(log2(BAUD_DIV+1)), clears on every bit transition; BAUD_DIV=1 gives one cycle per bit.
- `re` is never asserted when `empty`=1, `tx_en`=0, or outside the two pop points.
- `tx_en` is sampled only at pop points; deasserting mid-frame has no effect on the current frame.
- Reset values: `txd`=1, `re`=0, `busy`=0, `frame_done`=0, state IDLE, counters 0. Reset mid-frame aborts the frame; `txd` is 1 on the cycle after reset asserts, and the popped packet is discarded (not re-read).

## Timing
- Pop in cycle T -> `txd` falls at T+1 (start bit occupies T+1..T+BAUD_DIV).
- Data bit i occupies cycles T+1+(i+1)*BAUD_DIV .. T+(i+2)*BAUD_DIV.
- Frame length F = 12*BAUD_DIV cycles (13*BAUD_DIV with parity); stop bit is the last BAUD_DIV cycles; `frame_done` at T+F.
- Back-to-back: with FIFO non-empty, next `re` coincides with `frame_done`; the next start bit begins at T+F+1, no idle gap. Sustained throughput: one packet per F cycles.
- From IDLE, minimum latency `empty` falling -> `re` is 0 cycles (same cycle); `re` -> `txd` low is 1 cycle.

## Configuration
- `PKT_SER_PARITY_EN` defined: PAR state inserted after DATA, one bit of even parity (XOR of the 10 data bits), held BAUD_DIV cycles; frame is 13 bits.
- Undefined: no PAR state; frame is 12 bits (start, 10 data, stop); shift register and FSM carry no parity logic.

## Test plan
- Reset/idle: hold `rst` 3 cycles with `empty`=0 -> `txd`=1, `re`=0, `busy`=0, `frame_done`=0 throughout; first `re` in the first cycle after `rst` drops.
- Single frame, BAUD_DIV=4, `pkti`=10'h2A5, no macro: one `re` pulse; `txd` sequence per 4-cycle slot 0,1,0,1,0,0,1,0,1,0,1,1; `frame_done` at T+48.
- Parity, macro defined, same packet: 13 slots, parity slot = 1 (five ones), `frame_done` at T+52.
- Back-to-back, FIFO preloaded with 10'h001, 10'h3FF, 10'h155: three `re` pulses exactly 48 cycles apart, no idle high slot between stop and next start, then `busy`=0 and `re` quiet once `empty`=1.
- Flow control: drop `tx_en` mid-frame with FIFO non-empty -> current frame completes, no `re` at `frame_done`, FSM to IDLE; raise `tx_en` -> `re` same cycle.
- Reset mid-frame at data bit 5, BAUD_DIV=1: `txd`=1 next cycle, `busy`=0; after release the next FIFO word is popped, the aborted word is not re-sent.

Source files
------------

// File: rtl/pkt_ser.sv
// pkt_ser: drains a show-ahead FIFO and sends each 10-bit word LSB first as a UART-style frame.
// Optional macro PKT_SER_PARITY_EN appends an even-parity bit after the data bits.
module pkt_ser #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pkti,
  input  logic       empty,
  output logic       re,
  input  logic       tx_en,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);
  localparam int            BW        = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef PKT_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [9:0]    r_sh;
  logic          r_txd;
  logic          r_busy;
`ifdef PKT_SER_PARITY_EN
  logic          r_par;
`endif

  logic w_bit_end;
  logic w_pop;

  assign w_bit_end = (r_baud == BAUD_LAST);
  // Pop points: idle, or the last stop-bit cycle so back-to-back frames have no gap.
  assign w_pop = !rst && tx_en && !empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  assign re         = w_pop;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign frame_done = (r_state == STOP) && w_bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef PKT_SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if ((r_state == IDLE) || w_bit_end) r_baud <= '0;
      else                                r_baud <= r_baud + 1'b1;

      if (w_pop) begin
        r_sh    <= pkti;
        r_state <= START;
        r_txd   <= 1'b0;
        r_busy  <= 1'b1;
`ifdef PKT_SER_PARITY_EN
        r_par   <= ^pkti;
`endif
      end else begin
        case (r_state)
          IDLE: ;
          START: if (w_bit_end) begin
            r_state <= DATA;
            r_txd   <= r_sh[0];
            r_sh    <= {1'b0, r_sh[9:1]};
            r_bit   <= '0;
          end
          DATA: if (w_bit_end) begin
            if (r_bit == 4'd9) begin
`ifdef PKT_SER_PARITY_EN
              r_state <= PAR;
              r_txd   <= r_par;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_txd <= r_sh[0];
              r_sh  <= {1'b0, r_sh[9:1]};
              r_bit <= r_bit + 4'd1;
            end
          end
`ifdef PKT_SER_PARITY_EN
          PAR: if (w_bit_end) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
`endif
          STOP: if (w_bit_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pkt_ser.sv
// tb_pkt_ser: two serializers (bit period 4 and 1) fed from model FIFOs, checked cycle by cycle
// against a frame-timing reference model.
module tb_pkt_ser;
`ifdef PKT_SER_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int BD0 = 4;
  localparam int BD1 = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_en;
  logic [1:0]      empty, re, txd, busy, fdone;
  logic [1:0][9:0] pkti;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [9:0] fmem [2][256];
  logic [7:0] hd [2];
  logic [7:0] tl [2];
  bit         m_act [2];
  int         m_t0 [2];
  logic [9:0] m_w [2];
  int         re_log [8];
  int         n_re;

  always #5 clk = ~clk;

  pkt_ser #(.BAUD_DIV(BD0)) u_dut0 (
    .clk(clk), .rst(rst), .pkti(pkti[0]), .empty(empty[0]), .re(re[0]),
    .tx_en(tx_en), .txd(txd[0]), .busy(busy[0]), .frame_done(fdone[0]));

  pkt_ser #(.BAUD_DIV(BD1)) u_dut1 (
    .clk(clk), .rst(rst), .pkti(pkti[1]), .empty(empty[1]), .re(re[1]),
    .tx_en(tx_en), .txd(txd[1]), .busy(busy[1]), .frame_done(fdone[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Bit j of a frame: start, ten data bits LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [9:0] w, input int j);
    if (j == 0)  return 1'b0;
    if (j <= 10) return w[j-1];
`ifdef PKT_SER_PARITY_EN
    if (j == 11) return ^w;
`endif
    return 1'b1;
  endfunction

  function automatic int lvl(input int i);
    logic [7:0] d;
    d = tl[i] - hd[i];
    return int'(d);
  endfunction

  task automatic push(input int i, input logic [9:0] w);
    fmem[i][tl[i]] = w;
    tl[i] = tl[i] + 8'd1;
  endtask

  task automatic tick(input logic r, input logic en);
    rst   = r;
    tx_en = en;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (hd[i] == tl[i]);
      pkti[i]  = fmem[i][hd[i]];
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int   bd, f, k;
      logic e_re, e_txd, e_busy, e_fd, nonempty;
      bd       = (i == 0) ? BD0 : BD1;
      f        = NB * bd;
      k        = cyc - m_t0[i];
      nonempty = (hd[i] != tl[i]);
      e_txd    = m_act[i] ? frame_bit(m_w[i], (k - 1) / bd) : 1'b1;
      e_busy   = m_act[i];
      e_fd     = m_act[i] && (k == f);
      e_re     = !r && en && nonempty && (!m_act[i] || (k == f));
      check($sformatf("re%0d", i),    re[i],    e_re);
      check($sformatf("txd%0d", i),   txd[i],   e_txd);
      check($sformatf("busy%0d", i),  busy[i],  e_busy);
      check($sformatf("fdone%0d", i), fdone[i], e_fd);
      if (r) m_act[i] = 1'b0;
      else if (e_re) begin
        m_act[i] = 1'b1;
        m_t0[i]  = cyc;
        m_w[i]   = fmem[i][hd[i]];
      end else if (e_fd) m_act[i] = 1'b0;
      if (i == 0 && re[0] && n_re < 8) begin
        re_log[n_re] = cyc;
        n_re++;
      end
      if (re[i] && nonempty) hd[i] = hd[i] + 8'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic en;
    bit   drained;
    rst   = 1'b1;
    tx_en = 1'b0;
    empty = '1;
    pkti  = '0;
    n_re  = 0;
    for (int i = 0; i < 2; i++) begin
      hd[i] = '0; tl[i] = '0; m_act[i] = 1'b0; m_t0[i] = 0; m_w[i] = '0;
    end

    // Reset held with a word waiting, then a single frame.
    push(0, 10'h2A5); push(1, 10'h2A5);
    repeat (3) tick(1'b1, 1'b1);
    repeat (NB * BD0 + 4) tick(1'b0, 1'b1);

    // Back-to-back frames from a preloaded FIFO.
    n_re = 0;
    push(0, 10'h001); push(0, 10'h3FF); push(0, 10'h155);
    push(1, 10'h001); push(1, 10'h3FF); push(1, 10'h155);
    repeat (3 * NB * BD0 + 8) tick(1'b0, 1'b1);
    check("b2b_count", n_re, 3);
    check("b2b_gap1", re_log[1] - re_log[0], NB * BD0);
    check("b2b_gap2", re_log[2] - re_log[1], NB * BD0);

    // Flow control: tx_en dropped mid-frame, then raised.
    for (int j = 0; j < 4; j++) begin
      push(0, 10'($urandom)); push(1, 10'($urandom));
    end
    repeat (20) tick(1'b0, 1'b1);
    repeat (NB * BD0 + 10) tick(1'b0, 1'b0);
    repeat (4 * NB * BD0 + 10) tick(1'b0, 1'b1);

    // Reset during data bit 5 of the bit-period-1 instance.
    push(1, 10'h0F0); push(1, 10'h30F);
    push(0, 10'h0F0); push(0, 10'h30F);
    repeat (7) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    repeat (2 * NB * BD0 + 10) tick(1'b0, 1'b1);

    // Random traffic, tx_en toggling and rare resets.
    en = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0 && lvl(0) < 200) push(0, 10'($urandom));
      if ($urandom_range(0, 9) == 0 && lvl(1) < 200) push(1, 10'($urandom));
      if ($urandom_range(0, 99) == 0) en = !en;
      tick(($urandom_range(0, 799) == 0), en);
    end

    drained = 1'b0;
    for (int n = 0; n < 15000 && !drained; n++) begin
      tick(1'b0, 1'b1);
      drained = (lvl(0) == 0) && (lvl(1) == 0) && !m_act[0] && !m_act[1];
    end
    check("drain_done", drained, 1'b1);
    repeat (5) tick(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
